parking_lot_controller: RTL and testbench

//  Sequential controller for an 8-space lot. Arbitrates entry and exit gate requests and allocates
//  the lowest free space to each entering car. Retires spaces named by the exit keypad and keeps
//  the occupancy vector that drives the lot's space-indicator LEDs. Sits between the gate sensors
//  and keypad and the display/decoder logic.

---
 rtl/parking_lot_controller_pkg.sv | 18 +
 rtl/spot_allocator.sv | 19 +
 rtl/parking_lot_controller.sv | 102 ++++++++++
 tb/tb_parking_lot_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_lot_controller_pkg.sv
// Shared constants and types for the 8-space parking lot controller.
package parking_lot_controller_pkg;

  localparam int unsigned NUM_SPOTS = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned FREE_W    = 4;

  localparam logic [NUM_SPOTS-1:0] ALL_OCCUPIED = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ENTRY_GATE = 2'd1,
    ST_EXIT_GATE  = 2'd2,
    ST_ERR_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/spot_allocator.sv
// Priority encoder: lowest free space in the occupancy vector.
module spot_allocator
  import parking_lot_controller_pkg::*;
(
  input  logic [NUM_SPOTS-1:0] park_location,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 any_free
);

  // Scan from the top so the lowest zero bit is the last one written.
  always_comb begin
    free_idx = '0;
    any_free = (park_location != ALL_OCCUPIED);
    for (int i = int'(NUM_SPOTS) - 1; i >= 0; i--) begin
      if (!park_location[i]) free_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/parking_lot_controller.sv
// Gate arbitration, space allocation and occupancy tracking for the lot.
module parking_lot_controller
  import parking_lot_controller_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [IDX_W-1:0]     exit_number,
  output logic                 entry_ack,
  output logic [IDX_W-1:0]     entry_number,
  output logic                 exit_ack,
  output logic                 exit_err,
  output logic [NUM_SPOTS-1:0] park_location,
  output logic [FREE_W-1:0]    free_count,
  output logic                 full,
  output logic                 gate_open
);

  state_t                 state;
  logic [CNT_W-1:0]       gate_cnt;
  logic [IDX_W-1:0]       free_idx;
  logic                   any_free;
  logic [NUM_SPOTS-1:0]   exit_mask;
  logic [NUM_SPOTS-1:0]   entry_mask;
  logic                   exit_valid;

  spot_allocator u_spot_allocator (
    .park_location (park_location),
    .free_idx      (free_idx),
    .any_free      (any_free)
  );

  // Exit is legal only for a fully-known index naming an occupied space.
  always_comb begin
    exit_mask  = NUM_SPOTS'(1) << exit_number;
    entry_mask = NUM_SPOTS'(1) << free_idx;
    exit_valid = ((^exit_number) !== 1'bx) && ((park_location & exit_mask) != '0);
  end

  // Controller FSM with gate timer and occupancy register; exit wins over entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      gate_cnt      <= '0;
      entry_ack     <= 1'b0;
      entry_number  <= '0;
      exit_ack      <= 1'b0;
      exit_err      <= 1'b0;
      park_location <= '0;
      free_count    <= FREE_W'(NUM_SPOTS);
      full          <= 1'b0;
      gate_open     <= 1'b0;
    end else begin
      entry_ack <= 1'b0;
      exit_ack  <= 1'b0;
      exit_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (exit_req) begin
            if (exit_valid) begin
              state         <= ST_EXIT_GATE;
              exit_ack      <= 1'b1;
              park_location <= park_location & ~exit_mask;
              free_count    <= free_count + FREE_W'(1);
              full          <= 1'b0;
              gate_open     <= 1'b1;
              gate_cnt      <= CNT_W'(GATE_CYCLES - 1);
            end else begin
              state    <= ST_ERR_HOLD;
              exit_err <= 1'b1;
            end
          end else if (entry_req && any_free) begin
            state         <= ST_ENTRY_GATE;
            entry_ack     <= 1'b1;
            entry_number  <= free_idx;
            park_location <= park_location | entry_mask;
            free_count    <= free_count - FREE_W'(1);
            full          <= ((park_location | entry_mask) == ALL_OCCUPIED);
            gate_open     <= 1'b1;
            gate_cnt      <= CNT_W'(GATE_CYCLES - 1);
          end
        end
        ST_ENTRY_GATE, ST_EXIT_GATE: begin
          if (gate_cnt == '0) begin
            state     <= ST_IDLE;
            gate_open <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt - CNT_W'(1);
          end
        end
        ST_ERR_HOLD: begin
          if (!exit_req) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_lot_controller.sv
// Self-checking bench: transaction-level lot model plus directed and random traffic.
module tb_parking_lot_controller;

  localparam int GATE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req;
  logic       exit_req;
  logic [2:0] exit_number;
  logic       entry_ack;
  logic [2:0] entry_number;
  logic       exit_ack;
  logic       exit_err;
  logic [7:0] park_location;
  logic [3:0] free_count;
  logic       full;
  logic       gate_open;

  int n_cmp = 0;
  int n_err = 0;
  bit occ [8];

  always #5 clk = ~clk;

  parking_lot_controller #(.GATE_CYCLES(GATE)) dut (
    .clk           (clk),
    .reset         (reset),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .exit_number   (exit_number),
    .entry_ack     (entry_ack),
    .entry_number  (entry_number),
    .exit_ack      (exit_ack),
    .exit_err      (exit_err),
    .park_location (park_location),
    .free_count    (free_count),
    .full          (full),
    .gate_open     (gate_open)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 8; i++) if (!occ[i]) return i;
    return -1;
  endfunction

  function automatic int free_spaces();
    int n = 0;
    for (int i = 0; i < 8; i++) if (!occ[i]) n++;
    return n;
  endfunction

  function automatic logic [7:0] occ_vec();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = occ[i];
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check_val({tag, " park"}, park_location, occ_vec());
    check_val({tag, " free"}, free_count, free_spaces());
    check_val({tag, " full"}, full, free_spaces() == 0);
  endtask

  // Count gate-high cycles from the ack cycle on; stray acks are also counted.
  task automatic gate_window(input string tag);
    int g = 0;
    int extra = 0;
    while (gate_open && g < 40) begin
      g++;
      tick();
      if (gate_open && (entry_ack || exit_ack || exit_err)) extra++;
    end
    check_val({tag, " gate_width"}, g, GATE);
    check_val({tag, " stray_pulses"}, extra, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_number = '0;
    tick(); tick();
    for (int i = 0; i < 8; i++) occ[i] = 1'b0;
    check_val("rst entry_ack", entry_ack, 0);
    check_val("rst exit_ack", exit_ack, 0);
    check_val("rst exit_err", exit_err, 0);
    check_val("rst gate", gate_open, 0);
    check_val("rst entry_number", entry_number, 0);
    check_status("rst");
    reset = 1'b0;
    tick();
  endtask

  // Request entry from IDLE; expects grant of the lowest free space one cycle later.
  task automatic entry_txn(input string tag);
    int k = 0;
    int exp_idx = lowest_free();
    entry_req = 1'b1;
    do begin tick(); k++; end while (!entry_ack && k < 20);
    check_val({tag, " entry_latency"}, k, 1);
    entry_req = 1'b0;
    if (!entry_ack) return;
    check_val({tag, " entry_number"}, entry_number, exp_idx);
    if (exp_idx >= 0) occ[exp_idx] = 1'b1;
    check_status(tag);
    gate_window(tag);
  endtask

  // Request exit from IDLE; ok selects whether an ack or an error is expected.
  task automatic exit_txn(input string tag, input logic [2:0] num, input bit ok);
    int k = 0;
    int errs = 0;
    exit_req = 1'b1; exit_number = num;
    do begin tick(); k++; end while (!exit_ack && !exit_err && k < 20);
    check_val({tag, " exit_latency"}, k, 1);
    check_val({tag, " exit_ack"}, exit_ack, ok);
    check_val({tag, " exit_err"}, exit_err, !ok);
    if (ok) begin
      exit_req = 1'b0;
      occ[num] = 1'b0;
      check_status(tag);
      gate_window(tag);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tick();
        if (exit_err || exit_ack || gate_open) errs++;
      end
      check_val({tag, " held_err_pulses"}, errs, 0);
      check_status(tag);
      exit_req = 1'b0;
      tick(); tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    logic [2:0] n;
    do_reset();

    // Three grants from empty lot
    entry_txn("t1a"); entry_txn("t1b"); entry_txn("t1c");
    check_val("t1 park", park_location, 8'h07);
    check_val("t1 free", free_count, 5);

    // Release space 1, next entry reuses it
    exit_txn("t2 exit", 3'd1, 1'b1);
    check_val("t2 park", park_location, 8'h05);
    entry_txn("t2 entry");
    check_val("t2 entry_number", entry_number, 1);

    // Fill the lot, then pending entry while full
    for (int i = 0; i < 5; i++) entry_txn("t3 fill");
    check_val("t3 full", full, 1);
    entry_req = 1'b1; acks = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (entry_ack) acks++; end
    check_val("t3 no_ack_full", acks, 0);
    exit_req = 1'b1; exit_number = 3'd5;
    tick();
    check_val("t3 exit_ack", exit_ack, 1);
    check_val("t3 no_entry_ack", entry_ack, 0);
    exit_req = 1'b0; occ[5] = 1'b0;
    check_status("t3 exit");
    gate_window("t3 exit");
    entry_txn("t3 pending");
    check_val("t3 pending idx", entry_number, 5);

    // Simultaneous entry and exit: exit wins
    entry_req = 1'b1; exit_req = 1'b1; exit_number = 3'd3;
    tick();
    check_val("t4 exit_ack", exit_ack, 1);
    check_val("t4 entry_ack", entry_ack, 0);
    exit_req = 1'b0; occ[3] = 1'b0;
    check_status("t4 exit");
    gate_window("t4 exit");
    entry_txn("t4 entry");
    check_val("t4 entry idx", entry_number, 3);

    // Invalid exits on an empty lot
    do_reset();
    exit_txn("t5 unocc", 3'b110, 1'b0);
    exit_txn("t5 xnum", 3'bxxx, 1'b0);
    check_val("t5 park", park_location, 8'h00);

    // Reset in the middle of an entry gate
    entry_txn("t6 pre");
    entry_req = 1'b1;
    tick();
    check_val("t6 ack", entry_ack, 1);
    entry_req = 1'b0;
    tick();
    check_val("t6 gate_mid", gate_open, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) occ[i] = 1'b0;
    check_val("t6 gate", gate_open, 0);
    check_status("t6");
    entry_txn("t6 post");
    check_val("t6 post idx", entry_number, 0);

    // Random traffic
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 0 && free_spaces() > 0) begin
        entry_txn("rnd entry");
      end else begin
        n = 3'($urandom_range(0, 7));
        exit_txn("rnd exit", n, occ[n]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
